// File: rtl/mem_if.sv
// mem_if: request/response bus between requester and mem_responder, plus preload port.
interface mem_if #(parameter int ADDR_WIDTH = 16);
    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] address;
    logic [15:0]           wdata;
    logic                  init_we;
    logic [ADDR_WIDTH-1:0] init_addr;
    logic [15:0]           init_data;
    logic [15:0]           rdata;
    logic                  ack;
    logic                  busy;
    logic                  err;
    modport master (
        output mem_read, mem_write, address, wdata, init_we, init_addr, init_data,
        input  rdata, ack, busy, err
    );
    modport slave (
        input  mem_read, mem_write, address, wdata, init_we, init_addr, init_data,
        output rdata, ack, busy, err
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency word memory responder with one-cycle ack and range/protocol error pulses.
module mem_responder #(
    parameter int LATENCY    = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 256
) (
    input logic   clk,
    input logic   reset,
    mem_if.slave  bus
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    typedef enum logic {IDLE, ACCESS} state_t;
    state_t                state, state_n;
    logic [3:0]            cnt, cnt_n;
    logic                  op_wr;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [15:0]           wdata_q;
    logic [15:0]           mem [DEPTH];
    logic                  ack_n, err_n, busy_n, latch, commit, preload, upd_rd;
    logic                  in_range, init_in_range;
    assign in_range      = {1'b0, addr_q} < (ADDR_WIDTH+1)'(DEPTH);
    assign init_in_range = {1'b0, bus.init_addr} < (ADDR_WIDTH+1)'(DEPTH);
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ack_n   = 1'b0;
        err_n   = 1'b0;
        busy_n  = bus.busy;
        latch   = 1'b0;
        commit  = 1'b0;
        preload = 1'b0;
        upd_rd  = 1'b0;
        if (state == IDLE) begin
            if (bus.mem_read && bus.mem_write) begin
                err_n = 1'b1;
            end else if (bus.mem_read || bus.mem_write) begin
                latch   = 1'b1;
                cnt_n   = 4'(LATENCY - 1);
                busy_n  = 1'b1;
                state_n = ACCESS;
            end else begin
                preload = bus.init_we && init_in_range;
            end
        end else if (!(op_wr ? bus.mem_write : bus.mem_read)) begin
            // requester withdrew: abort silently
            state_n = IDLE;
            busy_n  = 1'b0;
        end else if (cnt != 4'd0) begin
            cnt_n = cnt - 4'd1;
        end else begin
            state_n = IDLE;
            busy_n  = 1'b0;
            ack_n   = 1'b1;
            err_n   = !in_range;
            upd_rd  = !op_wr;
            commit  = op_wr && in_range;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            bus.rdata <= 16'd0;
            bus.ack   <= 1'b0;
            bus.busy  <= 1'b0;
            bus.err   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bus.ack  <= ack_n;
            bus.busy <= busy_n;
            bus.err  <= err_n;
            if (upd_rd)
                bus.rdata <= in_range ? mem[addr_q[AW-1:0]] : 16'd0;
        end
    end
    always_ff @(posedge clk) begin
        if (latch) begin
            op_wr   <= bus.mem_write;
            addr_q  <= bus.address;
            wdata_q <= bus.wdata;
        end
    end
    // storage is never cleared; reset only blocks commits in its cycle
    always_ff @(posedge clk) begin
        if (!reset && commit)
            mem[addr_q[AW-1:0]] <= wdata_q;
        else if (!reset && preload)
            mem[bus.init_addr[AW-1:0]] <= bus.init_data;
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench; drivers queue expected acks, negedge monitors compare.
module tb_mem_responder;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;
    mem_if #(.ADDR_WIDTH(16)) b0();
    mem_if #(.ADDR_WIDTH(16)) b1();
    mem_responder #(.LATENCY(4), .ADDR_WIDTH(16), .DEPTH(256)) dut0 (.clk(clk), .reset(reset), .bus(b0.slave));
    mem_responder #(.LATENCY(1), .ADDR_WIDTH(16), .DEPTH(256)) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));
    typedef struct {
        int          cyc;
        logic        ack;
        logic        err;
        logic [15:0] rdata;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];
    int cyc = 0;
    int errors = 0;
    int checks = 0;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask
    always @(negedge clk) begin
        exp_t e;
        if (b0.ack || b0.err) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut0 unexpected response: ack=%b err=%b at cyc %0d", b0.ack, b0.err, cyc);
            end else begin
                e = q0.pop_front();
                chk("dut0 resp cycle", cyc, e.cyc);
                chk("dut0 ack", {31'd0, b0.ack}, {31'd0, e.ack});
                chk("dut0 err", {31'd0, b0.err}, {31'd0, e.err});
                chk("dut0 rdata", {16'd0, b0.rdata}, {16'd0, e.rdata});
            end
        end
    end
    always @(negedge clk) begin
        exp_t e;
        if (b1.ack || b1.err) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut1 unexpected response: ack=%b err=%b at cyc %0d", b1.ack, b1.err, cyc);
            end else begin
                e = q1.pop_front();
                chk("dut1 resp cycle", cyc, e.cyc);
                chk("dut1 ack", {31'd0, b1.ack}, {31'd0, e.ack});
                chk("dut1 err", {31'd0, b1.err}, {31'd0, e.err});
                chk("dut1 rdata", {16'd0, b1.rdata}, {16'd0, e.rdata});
            end
        end
    end
    task automatic preload0(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        b0.init_we = 1'b1; b0.init_addr = a; b0.init_data = d;
        @(negedge clk);
        b0.init_we = 1'b0;
    endtask
    task automatic preload1(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        b1.init_we = 1'b1; b1.init_addr = a; b1.init_data = d;
        @(negedge clk);
        b1.init_we = 1'b0;
    endtask
    // request held until ack, dropped in the ack cycle
    task automatic req0(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d,
                        input logic [15:0] exp_rd, input logic exp_err);
        @(negedge clk);
        b0.mem_read = rd; b0.mem_write = wr; b0.address = a; b0.wdata = d;
        q0.push_back('{cyc + 1 + 4, 1'b1, exp_err, exp_rd});
        for (int i = 0; i < 40 && !b0.ack; i++) @(negedge clk);
        if (!b0.ack) begin
            errors++;
            $display("FAIL dut0 ack timeout addr %0h", a);
        end
        b0.mem_read = 1'b0; b0.mem_write = 1'b0;
    endtask
    task automatic abort0(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        b0.mem_read = rd; b0.mem_write = wr; b0.address = a; b0.wdata = d;
        repeat (2) @(negedge clk);
        chk("abort busy before drop", {31'd0, b0.busy}, 32'd1);
        b0.mem_read = 1'b0; b0.mem_write = 1'b0;
        @(negedge clk);
        chk("abort busy after drop", {31'd0, b0.busy}, 32'd0);
        repeat (6) @(negedge clk);
    endtask
    initial begin
        int k;
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end
    initial begin
        int k;
        reset = 1'b1;
        {b0.mem_read, b0.mem_write, b0.init_we} = '0;
        {b1.mem_read, b1.mem_write, b1.init_we} = '0;
        b0.address = '0; b0.wdata = '0; b0.init_addr = '0; b0.init_data = '0;
        b1.address = '0; b1.wdata = '0; b1.init_addr = '0; b1.init_data = '0;
        repeat (3) @(negedge clk);
        chk("reset ack", {31'd0, b0.ack}, 32'd0);
        chk("reset busy", {31'd0, b0.busy}, 32'd0);
        chk("reset err", {31'd0, b0.err}, 32'd0);
        chk("reset rdata", {16'd0, b0.rdata}, 32'd0);
        chk("reset dut1 rdata", {16'd0, b1.rdata}, 32'd0);
        reset = 1'b0;
        preload0(16'h0010, 16'hBEEF);
        preload0(16'h0030, 16'h5555);
        req0(1'b1, 1'b0, 16'h0010, 16'h0, 16'hBEEF, 1'b0);
        repeat (3) @(negedge clk);
        chk("rdata held after read", {16'd0, b0.rdata}, 32'hBEEF);
        req0(1'b0, 1'b1, 16'h0020, 16'h1234, 16'hBEEF, 1'b0);
        req0(1'b1, 1'b0, 16'h0020, 16'h0, 16'h1234, 1'b0);
        abort0(1'b1, 1'b0, 16'h0010, 16'h0);
        chk("rdata after aborted read", {16'd0, b0.rdata}, 32'h1234);
        abort0(1'b0, 1'b1, 16'h0020, 16'hFFFF);
        req0(1'b1, 1'b0, 16'h0020, 16'h0, 16'h1234, 1'b0);
        @(negedge clk);
        b0.mem_read = 1'b1; b0.mem_write = 1'b1; b0.address = 16'h0010;
        q0.push_back('{cyc + 1, 1'b0, 1'b1, 16'h1234});
        @(negedge clk);
        b0.mem_read = 1'b0; b0.mem_write = 1'b0;
        chk("both-high busy", {31'd0, b0.busy}, 32'd0);
        @(negedge clk);
        chk("both-high err one cycle", {31'd0, b0.err}, 32'd0);
        req0(1'b1, 1'b0, 16'h0100, 16'h0, 16'h0000, 1'b1);
        @(negedge clk);
        b0.mem_write = 1'b1; b0.address = 16'h0030; b0.wdata = 16'hAAAA;
        repeat (2) @(negedge clk);
        reset = 1'b1; b0.mem_write = 1'b0;
        @(negedge clk);
        chk("mid-reset ack", {31'd0, b0.ack}, 32'd0);
        chk("mid-reset busy", {31'd0, b0.busy}, 32'd0);
        chk("mid-reset err", {31'd0, b0.err}, 32'd0);
        chk("mid-reset rdata", {16'd0, b0.rdata}, 32'd0);
        reset = 1'b0;
        req0(1'b1, 1'b0, 16'h0030, 16'h0, 16'h5555, 1'b0);
        req0(1'b1, 1'b0, 16'h0010, 16'h0, 16'hBEEF, 1'b0);
        preload1(16'h0040, 16'h4444);
        preload1(16'h0041, 16'h1111);
        @(negedge clk);
        b1.mem_read = 1'b1; b1.address = 16'h0040;
        k = cyc;
        q1.push_back('{k + 2, 1'b1, 1'b0, 16'h4444});
        q1.push_back('{k + 4, 1'b1, 1'b0, 16'h4444});
        q1.push_back('{k + 6, 1'b1, 1'b0, 16'h4444});
        repeat (6) @(negedge clk);
        b1.mem_read = 1'b0;
        @(negedge clk);
        b1.mem_read = 1'b1; b1.address = 16'h0041;
        b1.init_we = 1'b1; b1.init_addr = 16'h0041; b1.init_data = 16'h9999;
        q1.push_back('{cyc + 2, 1'b1, 1'b0, 16'h1111});
        @(negedge clk);
        b1.init_we = 1'b0;
        @(negedge clk);
        b1.mem_read = 1'b0;
        @(negedge clk);
        b1.mem_read = 1'b1;
        q1.push_back('{cyc + 2, 1'b1, 1'b0, 16'h1111});
        repeat (2) @(negedge clk);
        b1.mem_read = 1'b0;
        repeat (8) @(negedge clk);
        chk("dut0 pending responses", q0.size(), 32'd0);
        chk("dut1 pending responses", q1.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
